// File: rtl/tmr_decoder.sv
// TMR decoder: 2-stage majority vote of three copies with per-copy health FSMs.
// Optional macro TMR_ERR_CNT_EN builds the saturating corrected-word counter.
module tmr_decoder #(
  parameter int DATA_W      = 16,
  parameter int FAIL_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3*DATA_W-1:0]   code_in,
  input  logic                  valid_in,
  input  logic                  clear_stats,
  output logic [DATA_W-1:0]     data_out,
  output logic                  valid_out,
  output logic                  corrected,
  output logic [2:0]            copy_fault,
  output logic [2:0]            copy_failed,
  output logic [CNT_W-1:0]      err_count
);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_SUSPECT = 2'd1;
  localparam logic [1:0] ST_FAILED  = 2'd2;

  localparam logic [3:0] THRESH = 4'(FAIL_THRESH);

  logic [3*DATA_W-1:0] s1_code;
  logic                s1_valid;

  logic [DATA_W-1:0]   cp_a;
  logic [DATA_W-1:0]   cp_b;
  logic [DATA_W-1:0]   cp_c;
  logic [DATA_W-1:0]   vote;
  logic [2:0]          fault_c;
  logic                corr_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_code  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_code  <= code_in;
      s1_valid <= valid_in;
    end
  end

  assign cp_a = s1_code[3*DATA_W-1 -: DATA_W];
  assign cp_b = s1_code[2*DATA_W-1 -: DATA_W];
  assign cp_c = s1_code[DATA_W-1:0];

  assign vote = (cp_a & cp_b)
              | (cp_a & cp_c)
              | (cp_b & cp_c);

  assign fault_c[2] = |(cp_a ^ vote);
  assign fault_c[1] = |(cp_b ^ vote);
  assign fault_c[0] = |(cp_c ^ vote);
  assign corr_c     = |fault_c;

  // Bubbles leave the last word visible; only valid_out drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      corrected  <= 1'b0;
      copy_fault <= '0;
    end else begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        data_out   <= vote;
        corrected  <= corr_c;
        copy_fault <= fault_c;
      end
    end
  end

  // Health FSMs step on the same edge that publishes the word.
  for (genvar g = 0; g < 3; g++) begin : g_health
    logic [1:0] st;
    logic [1:0] st_nxt;
    logic [3:0] run;
    logic [3:0] run_nxt;
    logic [3:0] run_inc;
    logic       failed;

    assign run_inc = run + 4'd1;

    always_comb begin
      st_nxt  = st;
      run_nxt = run;
      if (clear_stats) begin
        st_nxt  = ST_OK;
        run_nxt = '0;
      end else if (s1_valid) begin
        unique case (st)
          ST_OK: begin
            if (fault_c[g]) begin
              run_nxt = 4'd1;
              st_nxt  = (THRESH == 4'd1) ? ST_FAILED
                                         : ST_SUSPECT;
            end
          end
          ST_SUSPECT: begin
            if (fault_c[g]) begin
              run_nxt = run_inc;
              if (run_inc == THRESH) begin
                st_nxt = ST_FAILED;
              end
            end else begin
              st_nxt  = ST_OK;
              run_nxt = '0;
            end
          end
          ST_FAILED: begin
            st_nxt = ST_FAILED;
          end
          default: begin
            st_nxt  = ST_OK;
            run_nxt = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st     <= ST_OK;
        run    <= '0;
        failed <= 1'b0;
      end else begin
        st     <= st_nxt;
        run    <= run_nxt;
        failed <= (st_nxt == ST_FAILED);
      end
    end

    assign copy_failed[g] = failed;
  end

`ifdef TMR_ERR_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear_stats) begin
      cnt <= '0;
    end else if (s1_valid && corr_c && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign err_count = cnt;
`else
  assign err_count = '0;
`endif

endmodule
